// File: rtl/addn_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder sequencer.
package addn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } addn_state_t;

    localparam int ADDN_BYTE_W = 8;
    localparam int ADDN_LEN_W  = 4;

endpackage

// File: rtl/add8_rc.sv
// Combinational 8-bit ripple-carry adder used as the shared byte datapath.
module add8_rc
    import addn_pkg::*;
(
    input  logic [ADDN_BYTE_W-1:0] A,
    input  logic [ADDN_BYTE_W-1:0] B,
    input  logic                   Cin,
    output logic [ADDN_BYTE_W-1:0] S,
    output logic                   Cout
);

    logic [ADDN_BYTE_W:0] carry;

    assign carry[0] = Cin;

    // One full adder per bit, carry rippling from bit 0 upward.
    for (genvar i = 0; i < ADDN_BYTE_W; i++) begin : g_fa
        assign S[i]         = A[i] ^ B[i] ^ carry[i];
        assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[ADDN_BYTE_W];

endmodule

// File: rtl/addn_seq.sv
// Byte-serial multi-byte adder sequencer: operand bytes arrive LSB-first,
// one shared 8-bit adder is reused per byte and the carry is chained
// through a register. Defining ADDN_SUB_EN adds a 'sub' port that turns
// the operation into A - B (A + ~B + 1); cout=1 then means no borrow.
module addn_seq
    import addn_pkg::*;
#(
    parameter int LEN_W = ADDN_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
`ifdef ADDN_SUB_EN
    input  logic                   sub,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDN_BYTE_W-1:0] a_byte,
    input  logic [ADDN_BYTE_W-1:0] b_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDN_BYTE_W-1:0] sum_byte,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   cout
);

    addn_state_t            state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   carry_q, carry_d;
    logic [ADDN_BYTE_W-1:0] sum_q, sum_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   cout_q, cout_d;
    logic                   done_q, done_d;

    logic [ADDN_BYTE_W-1:0] add_b;
    logic [ADDN_BYTE_W-1:0] add_s;
    logic                   add_cout;
    logic                   carry_init;
    logic                   xfer;
    logic                   consumed;

`ifdef ADDN_SUB_EN
    logic                   sub_q, sub_d;
    assign add_b      = sub_q ? ~b_byte : b_byte;
    assign carry_init = sub;
`else
    assign add_b      = b_byte;
    assign carry_init = 1'b0;
`endif

    add8_rc u_add8_rc (
        .A    (a_byte),
        .B    (add_b),
        .Cin  (carry_q),
        .S    (add_s),
        .Cout (add_cout)
    );

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign xfer      = in_valid && in_ready;
    assign consumed  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign sum_byte  = sum_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cout      = cout_q;

    // Next-state logic: sequencing, carry chaining and output register loading.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;
        done_d      = 1'b0;
`ifdef ADDN_SUB_EN
        sub_d       = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    len_d   = len;
                    cnt_d   = '0;
                    carry_d = carry_init;
                    cout_d  = 1'b0;
`ifdef ADDN_SUB_EN
                    sub_d   = sub;
`endif
                end
            end
            RUN: begin
                if (xfer) begin
                    sum_d       = add_s;
                    carry_d     = add_cout;
                    out_valid_d = 1'b1;
                    if (cnt_q == len_q) begin
                        out_last_d = 1'b1;
                        cout_d     = add_cout;
                        state_d    = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (consumed) begin
                    out_valid_d = 1'b0;
                end
            end
            FLUSH: begin
                if (consumed) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ADDN_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
            done_q      <= done_d;
`ifdef ADDN_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

endmodule

// File: tb/tb_addn_seq.sv
// Testbench for addn_seq. Compares sum bytes, out_last, cout and done
// against an arithmetic reference computed on whole operands.
// Define ADDN_SUB_EN to also exercise subtraction.
module tb_addn_seq;
    import addn_pkg::*;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          sub;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    sum_byte;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          cout;

    int checks   = 0;
    int failures = 0;

    // Results captured by the operation driver for each test to examine.
    int         obsCount;
    logic [7:0] obsSum [0:16];
    logic       obsLast [0:16];
    logic       obsCout;
    logic       firstReady;
    logic       doneAfter, busyAfter, coutAfter, doneAfter2;
    int         stallErrs, latErrs, busyErrs;
    logic       timedOut;

    addn_seq #(.LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
`ifdef ADDN_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_byte    (a_byte),
        .b_byte    (b_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_byte  (sum_byte),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .cout      (cout)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-operand reference: the low (lenM1+1) bytes of A and B added
    // (or A + ~B + 1 when subtracting); bit 8*(lenM1+1) is the final carry.
    function automatic logic [135:0] refResult(input int lenM1, input logic [127:0] a,
                                               input logic [127:0] b, input bit s);
        logic [135:0] mask, aa, bb;
        mask = (136'd1 << (8 * (lenM1 + 1))) - 136'd1;
        aa   = {8'd0, a} & mask;
        bb   = s ? ((~{8'd0, b}) & mask) : ({8'd0, b} & mask);
        return aa + bb + (s ? 136'd1 : 136'd0);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one full operation; readyMode 0 = out_ready held 1,
    // 1 = toggled 1/0, 2 = random with random input gaps.
    task automatic run_op(input int lenM1, input logic [127:0] a, input logic [127:0] b,
                          input bit s, input int readyMode, input bit startDuringRun);
        int   inIdx;
        bit   prevStall, prevXfer, lastDone, xfer;
        logic [7:0] prevSum;
        logic prevLast;
        obsCount  = 0; obsCout = 1'bx; stallErrs = 0; latErrs = 0; busyErrs = 0;
        timedOut  = 1'b1; doneAfter = 1'b0; busyAfter = 1'b1; coutAfter = 1'bx; doneAfter2 = 1'b1;
        inIdx = 0; prevStall = 0; prevXfer = 0; lastDone = 0; prevSum = '0; prevLast = 1'b0;
        start = 1'b1; len = LW'(lenM1); sub = s; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        firstReady = in_ready;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (prevStall && (sum_byte !== prevSum || out_last !== prevLast)) stallErrs++;
            if (prevXfer && out_valid !== 1'b1) latErrs++;
            if (busy !== 1'b1) busyErrs++;
            if (startDuringRun && cyc == 1) begin start = 1'b1; len = LW'(5); end
            else start = 1'b0;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (inIdx <= lenM1) begin
                in_valid = (readyMode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                a_byte   = a[8 * inIdx +: 8];
                b_byte   = b[8 * inIdx +: 8];
            end else begin
                in_valid = 1'b0;
                a_byte   = $urandom;
                b_byte   = $urandom;
            end
            #1;
            xfer = in_valid && in_ready;
            if (out_valid && !out_ready && in_ready) stallErrs++;
            if (out_valid && out_ready) begin
                if (obsCount <= 16) begin
                    obsSum[obsCount]  = sum_byte;
                    obsLast[obsCount] = out_last;
                end
                if (out_last) begin
                    obsCout  = cout;
                    lastDone = 1;
                end
                obsCount++;
            end
            prevStall = out_valid && !out_ready;
            prevSum   = sum_byte;
            prevLast  = out_last;
            prevXfer  = xfer;
            if (xfer) inIdx++;
            tick();
            if (lastDone) begin
                start = 1'b0; in_valid = 1'b0;
                doneAfter = done; busyAfter = busy; coutAfter = cout;
                tick();
                doneAfter2 = done;
                timedOut = 1'b0;
                break;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; sub = 1'b0; in_valid = 1'b0;
        a_byte = '0; b_byte = '0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (sum_byte !== 8'h00) begin failures++; $display("[TB] FAIL reset_sum got %h want 00", sum_byte); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got %b want 0", cout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        run_op(0, 128'hFF, 128'h01, 1'b0, 0, 1'b0);
        checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL single_timeout got %b want 0", timedOut); end
        checks++; if (firstReady !== 1'b1) begin failures++; $display("[TB] FAIL single_first_ready got %b want 1", firstReady); end
        checks++; if (obsCount !== 1) begin failures++; $display("[TB] FAIL single_count got %0d want 1", obsCount); end
        checks++; if (obsSum[0] !== 8'h00) begin failures++; $display("[TB] FAIL single_sum got %h want 00", obsSum[0]); end
        checks++; if (obsLast[0] !== 1'b1) begin failures++; $display("[TB] FAIL single_last got %b want 1", obsLast[0]); end
        checks++; if (obsCout !== 1'b1) begin failures++; $display("[TB] FAIL single_cout got %b want 1", obsCout); end
        checks++; if (doneAfter !== 1'b1) begin failures++; $display("[TB] FAIL single_done got %b want 1", doneAfter); end
        checks++; if (busyAfter !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got %b want 0", busyAfter); end
        checks++; if (doneAfter2 !== 1'b0) begin failures++; $display("[TB] FAIL single_done_width got %b want 0", doneAfter2); end
        tick(); tick();
        checks++; if (cout !== 1'b1) begin failures++; $display("[TB] FAIL single_cout_hold got %b want 1", cout); end
    endtask

    task automatic test_two_byte();
        run_op(1, 128'h00FF, 128'h0001, 1'b0, 0, 1'b0);
        checks++; if (obsCount !== 2) begin failures++; $display("[TB] FAIL two_count got %0d want 2", obsCount); end
        checks++; if (obsSum[0] !== 8'h00 || obsSum[1] !== 8'h01) begin failures++; $display("[TB] FAIL two_sums got %h %h want 00 01", obsSum[0], obsSum[1]); end
        checks++; if (obsLast[0] !== 1'b0 || obsLast[1] !== 1'b1) begin failures++; $display("[TB] FAIL two_last got %b%b want 01", obsLast[0], obsLast[1]); end
        checks++; if (obsCout !== 1'b0) begin failures++; $display("[TB] FAIL two_cout got %b want 0", obsCout); end
        checks++; if (latErrs !== 0) begin failures++; $display("[TB] FAIL two_latency got %0d errors want 0", latErrs); end
    endtask

    task automatic test_stall();
        run_op(3, 128'hFFFFFFFF, 128'h00000001, 1'b0, 1, 1'b0);
        checks++; if (obsCount !== 4) begin failures++; $display("[TB] FAIL stall_count got %0d want 4", obsCount); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (obsSum[i] !== 8'h00 || obsLast[i] !== (i == 3)) begin failures++; $display("[TB] FAIL stall_byte%0d got %h/%b want 00/%b", i, obsSum[i], obsLast[i], (i == 3)); end
        end
        checks++; if (stallErrs !== 0) begin failures++; $display("[TB] FAIL stall_hold got %0d errors want 0", stallErrs); end
        checks++; if (obsCout !== 1'b1) begin failures++; $display("[TB] FAIL stall_cout got %b want 1", obsCout); end
    endtask

    task automatic test_start_ignored();
        logic [127:0] a, b;
        logic [135:0] r;
        a = rand128(); b = rand128();
        r = refResult(2, a, b, 1'b0);
        run_op(2, a, b, 1'b0, 0, 1'b1);
        checks++; if (obsCount !== 3) begin failures++; $display("[TB] FAIL ignore_count got %0d want 3", obsCount); end
        checks++; if ({obsSum[2], obsSum[1], obsSum[0]} !== r[23:0]) begin failures++; $display("[TB] FAIL ignore_sum got %h want %h", {obsSum[2], obsSum[1], obsSum[0]}, r[23:0]); end
        checks++; if (busyErrs !== 0) begin failures++; $display("[TB] FAIL ignore_busy got %0d drops want 0", busyErrs); end
        checks++; if (doneAfter !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done got %b want 1", doneAfter); end
    endtask

    task automatic test_random();
        logic [127:0] a, b;
        logic [135:0] r;
        int n;
        for (int t = 0; t < 10; t++) begin
            n = (t == 0) ? 15 : $urandom_range(0, 15);
            a = rand128(); b = rand128();
            if (t == 1) begin a = '1; b = 128'd1; n = 15; end
            r = refResult(n, a, b, 1'b0);
            run_op(n, a, b, 1'b0, 2, 1'b0);
            checks++; if (obsCount !== n + 1 || timedOut !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_count got %0d want %0d", t, obsCount, n + 1); end
            for (int i = 0; i <= n; i++) begin
                checks++; if (obsSum[i] !== r[8 * i +: 8] || obsLast[i] !== (i == n)) begin failures++; $display("[TB] FAIL rand%0d_byte%0d got %h/%b want %h/%b", t, i, obsSum[i], obsLast[i], r[8 * i +: 8], (i == n)); end
            end
            checks++; if (obsCout !== r[8 * (n + 1)] || coutAfter !== r[8 * (n + 1)]) begin failures++; $display("[TB] FAIL rand%0d_cout got %b want %b", t, obsCout, r[8 * (n + 1)]); end
            checks++; if (stallErrs !== 0 || latErrs !== 0) begin failures++; $display("[TB] FAIL rand%0d_handshake got %0d/%0d errors want 0", t, stallErrs, latErrs); end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = LW'(3); sub = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1; a_byte = 8'h55; b_byte = 8'hAA;
        tick();
        a_byte = 8'hFF; b_byte = 8'h01;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if ({in_ready, out_valid, out_last, busy, done, cout} !== 6'b0 || sum_byte !== 8'h00) begin
            failures++; $display("[TB] FAIL midreset_outputs got %b%b%b%b%b%b/%h want 000000/00", in_ready, out_valid, out_last, busy, done, cout, sum_byte);
        end
        rst_n = 1'b1;
        tick();
        run_op(0, 128'h10, 128'h20, 1'b0, 0, 1'b0);
        checks++; if (obsCount !== 1 || obsSum[0] !== 8'h30) begin failures++; $display("[TB] FAIL midreset_sum got %0d/%h want 1/30", obsCount, obsSum[0]); end
        checks++; if (obsCout !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cout got %b want 0", obsCout); end
    endtask

`ifdef ADDN_SUB_EN
    task automatic test_sub();
        logic [127:0] a, b;
        logic [135:0] r;
        run_op(1, 128'h0100, 128'h0001, 1'b1, 0, 1'b0);
        checks++; if (obsCount !== 2 || obsSum[0] !== 8'hFF || obsSum[1] !== 8'h00) begin failures++; $display("[TB] FAIL sub_bytes got %h %h want FF 00", obsSum[0], obsSum[1]); end
        checks++; if (obsCout !== 1'b1) begin failures++; $display("[TB] FAIL sub_cout got %b want 1", obsCout); end
        for (int t = 0; t < 4; t++) begin
            a = rand128(); b = rand128();
            r = refResult(t * 4 + 1, a, b, 1'b1);
            run_op(t * 4 + 1, a, b, 1'b1, 2, 1'b0);
            for (int i = 0; i <= t * 4 + 1; i++) begin
                checks++; if (obsSum[i] !== r[8 * i +: 8]) begin failures++; $display("[TB] FAIL subrand%0d_byte%0d got %h want %h", t, i, obsSum[i], r[8 * i +: 8]); end
            end
            checks++; if (obsCout !== r[8 * (t * 4 + 2)]) begin failures++; $display("[TB] FAIL subrand%0d_cout got %b want %b", t, obsCout, r[8 * (t * 4 + 2)]); end
        end
    endtask
`endif

    // Scenario sequence followed by the one-line summary.
    initial begin
        test_reset();
        test_single_byte();
        test_two_byte();
        test_stall();
        test_start_ignored();
        test_random();
        test_reset_mid();
`ifdef ADDN_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/addn_seq.md
# addn_seq

Byte-serial multi-byte adder sequencer. Accepts operand byte pairs LSB-first over a valid/ready stream, drives one shared 8-bit ripple-carry adder per byte, chains the carry between bytes through a register, and emits sum bytes on an output stream. It sits between the tile's I/O capture logic and the 8-bit adder datapath, so operands of 1–16 bytes can be added without widening the datapath.

## Interface
Parameters:
- `LEN_W`, default 4: width of the length field; the maximum operand length is 2^LEN_W bytes.

Ports:
- `clk`  in  1  clock; the only clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `len`  in  LEN_W  operand length minus one (0 means 1 byte); sampled with `start`.
- `in_valid`  in  1  `a_byte`/`b_byte` are valid.
- `in_ready`  out  1  block accepts an operand pair this cycle.
- `a_byte`  in  8  operand A byte, LSB-first.
- `b_byte`  in  8  operand B byte, LSB-first.
- `out_valid`  out  1  `sum_byte` is valid.
- `out_ready`  in  1  downstream accepts `sum_byte`.
- `sum_byte`  out  8  sum byte, LSB-first.
- `out_last`  out  1  qualifies the final sum byte.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  one-cycle pulse when the final byte is consumed.
- `cout`  out  1  final carry out; held until the next accepted `start`.

## Operation
- FSM states: IDLE, RUN, FLUSH.
- IDLE → RUN when `start`=1. On this transition: latch `len`, clear the byte counter, clear the carry register, and clear `cout`.
- RUN:
  - `in_ready` = (!`out_valid` || `out_ready`).
  - A transfer occurs when `in_valid` && `in_ready`. On a transfer, {carry, `sum_byte`} ← `a_byte` + `b_byte` + carry. The output register is loaded, `out_valid` is set, and the counter increments.
  - When the transfer is for byte index == latched len, also set `out_last`, set `cout` to the new carry, and go to FLUSH.
- FLUSH: `in_ready` = 0. When `out_valid` && `out_ready`, clear `out_valid` and `out_last`, pulse `done`, and go to IDLE.
- In RUN, an output consumed with no new transfer in the same cycle clears `out_valid`.
- `start` is ignored outside IDLE. `in_valid` is ignored outside RUN.
- Arithmetic: 9-bit result. Bit 8 is the carry into the next byte. No overflow flag.
- Counter width is LEN_W and never wraps, because the transition at index == len precedes any wrap.
- Reset in any state: state goes to IDLE, and the carry and counter are cleared.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `sum_byte`=0x00, `out_last`=0, `busy`=0, `done`=0, `cout`=0.
- `start` to first `in_ready`=1: 1 cycle, because `in_ready` is high in the first RUN cycle.
- Input transfer to `out_valid`: 1 cycle (registered output).
- Throughput is 1 byte/cycle when `out_ready` is held at 1. A transfer and an output consumption in the same cycle are both allowed.
- While `out_valid` && !`out_ready`: `sum_byte` and `out_last` hold stable and `in_ready`=0.
- Last output consumed at cycle N: `done`=1 and `busy`=0 at N+1, and a new `start` is accepted at N+1.
- `cout` is valid from the cycle `out_last` rises.

## Configuration
- `ADDN_SUB_EN` defined: adds input port `sub` (1 bit), sampled with `start`.
  - When `sub`=1, the adder computes A + ~B + carry, and the carry register initialises to 1.
  - `cout`=1 means no borrow.
  - Length and handshake rules are unchanged.
- `ADDN_SUB_EN` undefined: there is no `sub` port. The block only adds, and the carry initialises to 0.

## Structure
- Package `addn_pkg`:
  - state enum `addn_state_t` (IDLE, RUN, FLUSH);
  - localparam `ADDN_BYTE_W` = 8;
  - default `LEN_W`.
- Sub-module `add8_rc`: combinational 8-bit ripple-carry adder with ports A, B, Cin, S, Cout. It is instantiated once as the shared datapath.
- FSM, counter, carry register and output register live in `addn_seq`.

## Test plan
- len=0, A=0xFF, B=0x01, `out_ready`=1 → `sum_byte`=0x00 with `out_last`=1, `cout`=1, `done` pulse one cycle after the consume.
- len=1, A=0x00FF, B=0x0001 (bytes FF/01, then 00/00) → output bytes 0x00, then 0x01; `out_last` on the 2nd byte only; `cout`=0.
- len=3, A=0xFFFFFFFF, B=0x00000001, `out_ready` toggled 1/0 each cycle → four 0x00 bytes, each held stable while stalled; `in_ready`=0 during stalls; `cout`=1.
- `start` pulsed during RUN with len=5 → ignored; the operation completes with the originally latched length; `busy` stays high until `done`.
- `rst_n`=0 after 2 of 4 bytes → next cycle all outputs are at reset values; a fresh len=0 operation, 0x10+0x20, yields 0x30 with `cout`=0.
- With `ADDN_SUB_EN`: `sub`=1, len=1, A=0x0100, B=0x0001 → bytes 0xFF, then 0x00; `cout`=1.
